mux_scan_sequencer: RTL and testbench

//  Upstream controller for the 4-bit 4:1 channel mux. Drives select lines {sel1,sel0} and steps them

---
 rtl/mux_scan_sequencer.sv | 130 +++++++++++++
 tb/tb_mux_scan_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// Round-robin select sequencer for a 4:1 channel mux. It steps through the enabled channels,
// waits for the mux output to settle, captures each word and hands it off with valid/ready.
module mux_scan_sequencer #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       enable_mask,
  input  logic [WIDTH-1:0] mux_out,
  output logic             sel1,
  output logic             sel0,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       chan_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NCH      = 4;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CH_W     = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_FIN
  } state_t;

  state_t           state;
  logic [NCH-1:0]   mask_q;
  logic [CNT_W-1:0] cnt;

  logic [CH_W-1:0]  cur_ch_c;
  logic [CH_W-1:0]  first_ch_c;
  logic [CH_W-1:0]  next_ch_c;
  logic             next_any_c;

  assign cur_ch_c = {sel1, sel0};

  // Lowest enabled channel of the incoming mask, used as the first select of a pass.
  always_comb begin
    first_ch_c = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (enable_mask[i]) first_ch_c = CH_W'(i);
    end
  end

  // Next enabled channel strictly above the current one; scanning never wraps.
  always_comb begin
    next_ch_c  = '0;
    next_any_c = 1'b0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (mask_q[i] && (CH_W'(i) > cur_ch_c)) begin
        next_ch_c  = CH_W'(i);
        next_any_c = 1'b1;
      end
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mask_q    <= '0;
      cnt       <= '0;
      sel1      <= 1'b0;
      sel0      <= 1'b0;
      data_out  <= '0;
      chan_out  <= '0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          {sel1, sel0} <= '0;
          if (start) begin
            mask_q <= enable_mask;
            if (|enable_mask) begin
              {sel1, sel0} <= first_ch_c;
              cnt          <= '0;
              busy         <= 1'b1;
              state        <= S_WAIT;
            end else begin
              done  <= 1'b1;
              state <= S_FIN;
            end
          end
        end
        S_WAIT: begin
          if (cnt == CNT_LAST) begin
            data_out  <= mux_out;
            chan_out  <= cur_ch_c;
            valid_out <= 1'b1;
            state     <= S_HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (ready_in) begin
            valid_out <= 1'b0;
            if (next_any_c) begin
              {sel1, sel0} <= next_ch_c;
              cnt          <= '0;
              state        <= S_WAIT;
            end else begin
              {sel1, sel0} <= '0;
              busy         <= 1'b0;
              done         <= 1'b1;
              state        <= S_FIN;
            end
          end
        end
        S_FIN: begin
          {sel1, sel0} <= '0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: a behavioural mux feeds the DUT and a queue of
// expected (channel, word) transfers is compared against every valid/ready handshake.
module tb_mux_scan_sequencer;

  localparam int unsigned WIDTH = 4;

  typedef struct packed {
    logic [1:0]       chan;
    logic [WIDTH-1:0] data;
  } xfer_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, ready_in;
  logic [3:0]       enable_mask;
  logic [WIDTH-1:0] mux_out, data_out;
  logic             sel1, sel0, valid_out, busy, done;
  logic [1:0]       chan_out;

  logic             start3, ready3;
  logic [3:0]       mask3;
  logic [WIDTH-1:0] mux_out3, data_out3;
  logic             sel1_3, sel0_3, valid3, busy3, done3;
  logic [1:0]       chan3;

  int    checks   = 0;
  int    failures = 0;
  xfer_t exp_q[$];

  function automatic logic [WIDTH-1:0] mux_model(input logic [1:0] s);
    case (s)
      2'd0:    return 4'b0101;
      2'd1:    return 4'b1010;
      2'd2:    return 4'b1100;
      default: return 4'b0011;
    endcase
  endfunction

  assign mux_out  = mux_model({sel1, sel0});
  assign mux_out3 = mux_model({sel1_3, sel0_3});

  always #5 clk = ~clk;

  mux_scan_sequencer #(.WIDTH(WIDTH), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .enable_mask(enable_mask), .mux_out(mux_out),
    .sel1(sel1), .sel0(sel0), .data_out(data_out), .chan_out(chan_out),
    .valid_out(valid_out), .ready_in(ready_in), .busy(busy), .done(done)
  );

  mux_scan_sequencer #(.WIDTH(WIDTH), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .enable_mask(mask3), .mux_out(mux_out3),
    .sel1(sel1_3), .sel0(sel0_3), .data_out(data_out3), .chan_out(chan3),
    .valid_out(valid3), .ready_in(ready3), .busy(busy3), .done(done3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; ready_in = 1'b0; enable_mask = '0;
    start3 = 1'b0; ready3 = 1'b0; mask3 = '0;
    #3;
    checks++;
    if ({sel1, sel0, data_out, chan_out, valid_out, busy, done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got %b want 0",
               {sel1, sel0, data_out, chan_out, valid_out, busy, done});
    end
    checks++;
    if ({sel1_3, sel0_3, data_out3, chan3, valid3, busy3, done3} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_s3 got %b want 0",
               {sel1_3, sel0_3, data_out3, chan3, valid3, busy3, done3});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({valid_out, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got %b want 000", {valid_out, busy, done});
    end
  endtask

  // Full scan; a second start while busy and a mask change mid-pass must have no effect.
  task automatic test_full_scan();
    xfer_t want, got;
    exp_q.push_back(xfer_t'{2'd0, 4'b0101});
    exp_q.push_back(xfer_t'{2'd1, 4'b1010});
    exp_q.push_back(xfer_t'{2'd2, 4'b1100});
    exp_q.push_back(xfer_t'{2'd3, 4'b0011});
    enable_mask = 4'hF; ready_in = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      start = (cyc == 5);
      if (cyc >= 3) enable_mask = 4'h0;
      checks++;
      if (busy !== (cyc <= 8)) begin
        failures++;
        $display("FAIL t1_busy cyc%0d got %b want %b", cyc, busy, (cyc <= 8));
      end
      checks++;
      if (valid_out !== ((cyc % 2 == 0) && cyc <= 8)) begin
        failures++;
        $display("FAIL t1_valid cyc%0d got %b want %b", cyc, valid_out, ((cyc % 2 == 0) && cyc <= 8));
      end
      checks++;
      if (done !== (cyc == 9)) begin
        failures++;
        $display("FAIL t1_done cyc%0d got %b want %b", cyc, done, (cyc == 9));
      end
      if (valid_out && ready_in) begin
        got = {chan_out, data_out};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL t1_extra_xfer cyc%0d got %h want none", cyc, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL t1_xfer cyc%0d got chan%0d/%b want chan%0d/%b",
                     cyc, got.chan, got.data, want.chan, want.data);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL t1_missing got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
    start = 1'b0;
  endtask

  task automatic test_sparse_mask();
    xfer_t want, got;
    int ndone = 0;
    exp_q.push_back(xfer_t'{2'd1, 4'b1010});
    exp_q.push_back(xfer_t'{2'd3, 4'b0011});
    enable_mask = 4'b1010; ready_in = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      start = 1'b0;
      if (done) ndone++;
      if (busy) begin
        checks++;
        if (sel0 !== 1'b1) begin
          failures++;
          $display("FAIL t2_sel cyc%0d got %b%b want x1", cyc, sel1, sel0);
        end
      end
      checks++;
      if (valid_out !== (cyc == 2 || cyc == 4)) begin
        failures++;
        $display("FAIL t2_valid cyc%0d got %b want %b", cyc, valid_out, (cyc == 2 || cyc == 4));
      end
      if (valid_out && ready_in) begin
        got = {chan_out, data_out};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL t2_extra_xfer cyc%0d got %h want none", cyc, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL t2_xfer cyc%0d got chan%0d/%b want chan%0d/%b",
                     cyc, got.chan, got.data, want.chan, want.data);
          end
        end
      end
    end
    checks++;
    if (ndone != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL t2_end got done=%0d pending=%0d want done=1 pending=0", ndone, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    xfer_t want, got;
    int ndone = 0;
    exp_q.push_back(xfer_t'{2'd0, 4'b0101});
    exp_q.push_back(xfer_t'{2'd1, 4'b1010});
    exp_q.push_back(xfer_t'{2'd2, 4'b1100});
    exp_q.push_back(xfer_t'{2'd3, 4'b0011});
    enable_mask = 4'hF; ready_in = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      start = 1'b0;
      ready_in = (cyc >= 7);
      if (done) ndone++;
      if (cyc >= 2 && cyc <= 6) begin
        checks++;
        if ({valid_out, data_out, sel1, sel0} !== {1'b1, 4'b0101, 2'b00}) begin
          failures++;
          $display("FAIL t3_stall cyc%0d got v=%b d=%b sel=%b%b want v=1 d=0101 sel=00",
                   cyc, valid_out, data_out, sel1, sel0);
        end
      end
      if (cyc == 8) begin
        checks++;
        if ({valid_out, sel1, sel0} !== 3'b001) begin
          failures++;
          $display("FAIL t3_resume cyc%0d got v=%b sel=%b%b want v=0 sel=01",
                   cyc, valid_out, sel1, sel0);
        end
      end
      if (valid_out && ready_in) begin
        got = {chan_out, data_out};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL t3_extra_xfer cyc%0d got %h want none", cyc, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL t3_xfer cyc%0d got chan%0d/%b want chan%0d/%b",
                     cyc, got.chan, got.data, want.chan, want.data);
          end
        end
      end
    end
    checks++;
    if (ndone != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL t3_end got done=%0d pending=%0d want done=1 pending=0", ndone, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_empty_mask();
    enable_mask = 4'h0; ready_in = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      tick();
      start = 1'b0;
      checks++;
      if ({valid_out, busy, done} !== {2'b00, (cyc == 1)}) begin
        failures++;
        $display("FAIL t4_empty cyc%0d got v/b/d=%b want %b", cyc, {valid_out, busy, done},
                 {2'b00, (cyc == 1)});
      end
    end
  endtask

  task automatic test_async_reset();
    xfer_t want, got;
    int ndone = 0;
    enable_mask = 4'hF; ready_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (valid_out !== 1'b1) begin
      failures++;
      $display("FAIL t5_pre_valid got %b want 1", valid_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sel1, sel0, data_out, chan_out, valid_out, busy, done} !== '0) begin
      failures++;
      $display("FAIL t5_async_clear got %b want 0",
               {sel1, sel0, data_out, chan_out, valid_out, busy, done});
    end
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      checks++;
      if ({valid_out, busy, done} !== 3'b000) begin
        failures++;
        $display("FAIL t5_post_idle cyc%0d got %b want 000", cyc, {valid_out, busy, done});
      end
    end
    exp_q.push_back(xfer_t'{2'd0, 4'b0101});
    exp_q.push_back(xfer_t'{2'd1, 4'b1010});
    exp_q.push_back(xfer_t'{2'd2, 4'b1100});
    exp_q.push_back(xfer_t'{2'd3, 4'b0011});
    ready_in = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      start = 1'b0;
      if (done) ndone++;
      if (valid_out && ready_in) begin
        got = {chan_out, data_out};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL t5_extra_xfer cyc%0d got %h want none", cyc, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL t5_xfer cyc%0d got chan%0d/%b want chan%0d/%b",
                     cyc, got.chan, got.data, want.chan, want.data);
          end
        end
      end
    end
    checks++;
    if (ndone != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL t5_end got done=%0d pending=%0d want done=1 pending=0", ndone, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_long_settle();
    xfer_t want, got;
    exp_q.push_back(xfer_t'{2'd2, 4'b1100});
    mask3 = 4'b0100; ready3 = 1'b1; start3 = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      tick();
      start3 = 1'b0;
      if (cyc <= 4) begin
        checks++;
        if ({sel1_3, sel0_3} !== 2'b10) begin
          failures++;
          $display("FAIL t6_sel cyc%0d got %b%b want 10", cyc, sel1_3, sel0_3);
        end
      end
      checks++;
      if ({valid3, done3} !== {(cyc == 4), (cyc == 5)}) begin
        failures++;
        $display("FAIL t6_timing cyc%0d got v/d=%b want %b", cyc, {valid3, done3},
                 {(cyc == 4), (cyc == 5)});
      end
      if (valid3 && ready3) begin
        got = {chan3, data_out3};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL t6_extra_xfer cyc%0d got %h want none", cyc, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL t6_xfer cyc%0d got chan%0d/%b want chan%0d/%b",
                     cyc, got.chan, got.data, want.chan, want.data);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL t6_missing got %0d pending want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_full_scan();
    tick();
    test_sparse_mask();
    tick();
    test_backpressure();
    tick();
    test_empty_mask();
    tick();
    test_async_reset();
    tick();
    test_long_settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
